fpu_addsub_issue_ctrl: RTL and testbench

//  Requester side of the add/subtract unit's beg_FSM/ready/rst_FSM handshake. Accepts one operation from
//  an upstream valid/ready port, holds operands stable on the unit's inputs and pulses beg_FSM.

---
 rtl/fpu_addsub_issue_pkg.sv | 20 ++
 rtl/fpu_wdog_counter.sv | 32 +++
 rtl/fpu_addsub_issue_ctrl.sv | 142 ++++++++++++++
 tb/tb_fpu_addsub_issue_ctrl.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_addsub_issue_pkg.sv
// Shared types and defaults for the add/subtract unit issue controller.
package fpu_addsub_issue_pkg;

  localparam int DEF_W       = 32;
  localparam int DEF_TIMEOUT = 64;
  localparam int DEF_CW      = 7;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_ACK   = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    START = ST_START,
    WAIT  = ST_WAIT,
    ACK   = ST_ACK
  } state_t;

endpackage

// File: rtl/fpu_wdog_counter.sv
// Clear/enable saturating counter with a terminal-count compare, used as the
// WAIT-state watchdog and latency counter.
module fpu_wdog_counter #(
  parameter int CW = 7,
  parameter int TC = 63
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  output logic [CW-1:0] count,
  output logic          tc
);

  localparam logic [CW-1:0] MAX_V = '1;
  localparam logic [CW-1:0] TC_V  = CW'(TC);

  // Count up while enabled, hold at all-ones, clear has priority over enable.
  always_ff @(posedge clk) begin
    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != MAX_V)) begin
      count <= count + CW'(1);
    end
  end

  assign tc = (count == TC_V);

endmodule

// File: rtl/fpu_addsub_issue_ctrl.sv
// Requester side of the add/subtract unit handshake: accepts one operation,
// holds operands, pulses beg_FSM, captures the result on ready (or aborts on
// watchdog expiry), pulses rst_FSM and presents the result downstream.
module fpu_addsub_issue_ctrl
  import fpu_addsub_issue_pkg::*;
#(
  parameter int W       = DEF_W,
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int CW      = DEF_CW
) (
  input  logic          clk,
  input  logic          rst,
  // upstream operation port
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_x,
  input  logic [W-1:0]  in_y,
  input  logic          in_add_subt,
  input  logic [1:0]    in_r_mode,
  // add/subtract unit side
  output logic          fpu_beg_FSM,
  output logic          fpu_rst_FSM,
  output logic [W-1:0]  fpu_Data_X,
  output logic [W-1:0]  fpu_Data_Y,
  output logic          fpu_add_subt,
  output logic [1:0]    fpu_r_mode,
  input  logic          fpu_ready,
  input  logic [W-1:0]  fpu_result,
  input  logic          fpu_ovf,
  input  logic          fpu_unf,
  // downstream result port
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_result,
  output logic          out_ovf,
  output logic          out_unf,
  output logic          out_timeout,
  output logic [CW-1:0] out_cycles,
  output logic          busy
);

  state_t        state;
  logic          accept;
  logic          pop;
  logic [CW-1:0] wdog_count;
  logic          wdog_tc;
  logic [CW-1:0] cycles_inc;

  // A new op may enter only from IDLE and only if the result buffer is, or
  // is about to become, empty; this keeps the buffer from ever being overwritten.
  assign in_ready = (state == IDLE) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign pop      = out_valid && out_ready;
  assign busy     = (state != IDLE);

  // Counter holds the number of WAIT cycles already completed, so the cycle
  // that resolves the op is the (count+1)-th one.
  assign cycles_inc = (wdog_count == '1) ? wdog_count : wdog_count + CW'(1);

  fpu_wdog_counter #(
    .CW (CW),
    .TC (TIMEOUT - 1)
  ) u_wdog (
    .clk   (clk),
    .rst   (rst),
    .clr   (accept),
    .en    (state == WAIT),
    .count (wdog_count),
    .tc    (wdog_tc)
  );

  // Issue FSM with registered pulses, operand registers and result buffer.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= IDLE;
      fpu_beg_FSM  <= 1'b0;
      fpu_rst_FSM  <= 1'b0;
      fpu_Data_X   <= '0;
      fpu_Data_Y   <= '0;
      fpu_add_subt <= 1'b0;
      fpu_r_mode   <= 2'b00;
      out_valid    <= 1'b0;
      out_result   <= '0;
      out_ovf      <= 1'b0;
      out_unf      <= 1'b0;
      out_timeout  <= 1'b0;
      out_cycles   <= '0;
    end else begin
      // NOTE: pulses default low every cycle; the state cases below raise them
      // for exactly one cycle, and a later assignment in the block wins.
      fpu_beg_FSM <= 1'b0;
      fpu_rst_FSM <= 1'b0;
      if (pop) begin
        out_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (accept) begin
            fpu_Data_X   <= in_x;
            fpu_Data_Y   <= in_y;
            fpu_add_subt <= in_add_subt;
            fpu_r_mode   <= in_r_mode;
            fpu_beg_FSM  <= 1'b1;
            state        <= START;
          end
        end
        START: begin
          state <= WAIT;
        end
        WAIT: begin
          if (fpu_ready) begin
            out_result  <= fpu_result;
            out_ovf     <= fpu_ovf;
            out_unf     <= fpu_unf;
            out_timeout <= 1'b0;
            out_cycles  <= cycles_inc;
            out_valid   <= 1'b1;
            fpu_rst_FSM <= 1'b1;
            state       <= ACK;
          end else if (wdog_tc) begin
            out_result  <= '0;
            out_ovf     <= 1'b0;
            out_unf     <= 1'b0;
            out_timeout <= 1'b1;
            out_cycles  <= CW'(TIMEOUT);
            out_valid   <= 1'b1;
            fpu_rst_FSM <= 1'b1;
            state       <= ACK;
          end
        end
        ACK: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_addsub_issue_ctrl.sv
// Directed bench for fpu_addsub_issue_ctrl with a behavioural add/sub unit stub.
module tb_fpu_addsub_issue_ctrl;

  localparam int W  = 32;
  localparam int CW = 7;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_x;
  logic [W-1:0]  in_y;
  logic          in_add_subt;
  logic [1:0]    in_r_mode;
  logic          fpu_beg_FSM;
  logic          fpu_rst_FSM;
  logic [W-1:0]  fpu_Data_X;
  logic [W-1:0]  fpu_Data_Y;
  logic          fpu_add_subt;
  logic [1:0]    fpu_r_mode;
  logic          fpu_ready;
  logic [W-1:0]  fpu_result;
  logic          fpu_ovf;
  logic          fpu_unf;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_result;
  logic          out_ovf;
  logic          out_unf;
  logic          out_timeout;
  logic [CW-1:0] out_cycles;
  logic          busy;

  fpu_addsub_issue_ctrl #(.W(W), .TIMEOUT(64), .CW(CW)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_x         (in_x),
    .in_y         (in_y),
    .in_add_subt  (in_add_subt),
    .in_r_mode    (in_r_mode),
    .fpu_beg_FSM  (fpu_beg_FSM),
    .fpu_rst_FSM  (fpu_rst_FSM),
    .fpu_Data_X   (fpu_Data_X),
    .fpu_Data_Y   (fpu_Data_Y),
    .fpu_add_subt (fpu_add_subt),
    .fpu_r_mode   (fpu_r_mode),
    .fpu_ready    (fpu_ready),
    .fpu_result   (fpu_result),
    .fpu_ovf      (fpu_ovf),
    .fpu_unf      (fpu_unf),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_ovf      (out_ovf),
    .out_unf      (out_unf),
    .out_timeout  (out_timeout),
    .out_cycles   (out_cycles),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // ---------------- unit stub ----------------
  logic          stub_random;
  logic [7:0]    stub_delay;
  logic [W-1:0]  fixed_res;
  logic          fixed_ovf;
  logic          fixed_unf;
  logic          stub_arm;
  logic [7:0]    stub_cnt;
  logic [7:0]    cur_delay;

  function automatic logic [31:0] mix(input logic [31:0] x, input logic [31:0] y, input logic op);
    return x ^ {y[15:0], y[31:16]} ^ {32{op}};
  endfunction

  assign cur_delay = stub_random ? (8'(fpu_Data_X[3:0] % 4'd10) + 8'd1) : stub_delay;

  // Stub raises ready in the cur_delay-th cycle after beg_FSM (0 = never) and
  // holds it until rst_FSM.
  always @(posedge clk) begin
    if (!rst) begin
      fpu_ready  <= 1'b0;
      fpu_result <= '0;
      fpu_ovf    <= 1'b0;
      fpu_unf    <= 1'b0;
      stub_arm   <= 1'b0;
      stub_cnt   <= '0;
    end else if (fpu_rst_FSM) begin
      fpu_ready <= 1'b0;
      stub_arm  <= 1'b0;
    end else if (fpu_beg_FSM) begin
      fpu_result <= stub_random ? mix(fpu_Data_X, fpu_Data_Y, fpu_add_subt) : fixed_res;
      fpu_ovf    <= stub_random ? (fpu_Data_X[4] ^ fpu_Data_Y[0]) : fixed_ovf;
      fpu_unf    <= stub_random ? fpu_Data_Y[5] : fixed_unf;
      if (cur_delay == 8'd1) begin
        fpu_ready <= 1'b1;
      end else if (cur_delay != 8'd0) begin
        stub_arm <= 1'b1;
        stub_cnt <= cur_delay - 8'd1;
      end
    end else if (stub_arm) begin
      if (stub_cnt == 8'd1) begin
        fpu_ready <= 1'b1;
        stub_arm  <= 1'b0;
      end else begin
        stub_cnt <= stub_cnt - 8'd1;
      end
    end
  end

  // ---------------- handshake monitor ----------------
  int           beg_cnt = 0;
  int           rstfsm_cnt = 0;
  int           viol = 0;
  logic         in_flight = 1'b0;
  logic         prev_beg = 1'b0;
  logic         prev_rstfsm = 1'b0;
  logic [W-1:0] held_x = '0;
  logic [W-1:0] held_y = '0;

  // Pulse widths, no beg_FSM while an op is in flight, operand stability.
  always @(negedge clk) begin
    if (fpu_beg_FSM) beg_cnt <= beg_cnt + 1;
    if (fpu_rst_FSM) rstfsm_cnt <= rstfsm_cnt + 1;
    if (fpu_beg_FSM && (in_flight || prev_beg)) viol <= viol + 1;
    if (fpu_rst_FSM && prev_rstfsm) viol <= viol + 1;
    if (busy && in_flight && !fpu_beg_FSM && (fpu_Data_X != held_x || fpu_Data_Y != held_y))
      viol <= viol + 1;
    if (fpu_beg_FSM) begin
      held_x <= fpu_Data_X;
      held_y <= fpu_Data_Y;
    end
    prev_beg    <= fpu_beg_FSM;
    prev_rstfsm <= fpu_rst_FSM;
    if (fpu_beg_FSM)                 in_flight <= 1'b1;
    else if (fpu_rst_FSM || !busy)   in_flight <= 1'b0;
  end

  // ---------------- helpers ----------------
  task automatic issue(input string tag, input logic [31:0] x, input logic [31:0] y,
                       input logic op, input logic [1:0] rm);
    in_x = x; in_y = y; in_add_subt = op; in_r_mode = rm; in_valid = 1'b1;
    #1;
    check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    check({tag, "_beg"}, 64'(fpu_beg_FSM), 64'd1);
  endtask

  task automatic wait_out(output int n);
    n = 0;
    while (!out_valid && n < 200) begin
      tick();
      n++;
    end
  endtask

  typedef struct {
    logic [31:0]   res;
    logic          ovf;
    logic          unf;
    logic [CW-1:0] cyc;
  } exp_t;

  exp_t exp_q[$];

  // ---------------- directed sequence ----------------
  initial begin
    int n;
    int saved;
    int issued;
    int rx;
    int guard;
    logic acc;
    exp_t e;

    rst = 1'b0; in_valid = 1'b0; in_x = '0; in_y = '0; in_add_subt = 1'b0; in_r_mode = 2'b00;
    out_ready = 1'b0; stub_random = 1'b0; stub_delay = 8'd0;
    fixed_res = '0; fixed_ovf = 1'b0; fixed_unf = 1'b0;

    // Reset state
    repeat (2) tick();
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_beg", 64'(fpu_beg_FSM), 64'd0);
    check("rst_rstfsm", 64'(fpu_rst_FSM), 64'd0);
    check("rst_data_x", 64'(fpu_Data_X), 64'd0);
    check("rst_out_cycles", 64'(out_cycles), 64'd0);
    rst = 1'b1;
    tick();

    // Single add, result after 5 WAIT cycles, downstream stalled
    stub_delay = 8'd5; fixed_res = 32'h40400000;
    issue("add", 32'h3F800000, 32'h40000000, 1'b0, 2'd2);
    check("add_data_x", 64'(fpu_Data_X), 64'h3F800000);
    check("add_data_y", 64'(fpu_Data_Y), 64'h40000000);
    check("add_op", 64'(fpu_add_subt), 64'd0);
    check("add_rmode", 64'(fpu_r_mode), 64'd2);
    check("add_busy", 64'(busy), 64'd1);
    check("add_in_ready_busy", 64'(in_ready), 64'd0);
    wait_out(n);
    check("add_latency", 64'(n), 64'd6);
    check("add_result", 64'(out_result), 64'h40400000);
    check("add_cycles", 64'(out_cycles), 64'd5);
    check("add_timeout", 64'(out_timeout), 64'd0);
    check("add_rstfsm", 64'(fpu_rst_FSM), 64'd1);

    // Back-pressure: hold for 10 cycles with a new op pending
    stub_delay = 8'd1; fixed_res = 32'h40000000;
    in_x = 32'h40400000; in_y = 32'h3F800000; in_add_subt = 1'b1; in_r_mode = 2'd1; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_valid", 64'(out_valid), 64'd1);
      check("bp_result", 64'(out_result), 64'h40400000);
      check("bp_in_ready", 64'(in_ready), 64'd0);
    end
    check("bp_data_x_kept", 64'(fpu_Data_X), 64'h3F800000);
    check("add_beg_count", 64'(beg_cnt), 64'd1);
    check("add_rstfsm_count", 64'(rstfsm_cnt), 64'd1);
    out_ready = 1'b1;
    #1;
    check("bp_release_in_ready", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    check("bp_popped", 64'(out_valid), 64'd0);
    check("bp_new_beg", 64'(fpu_beg_FSM), 64'd1);
    check("bp_new_x", 64'(fpu_Data_X), 64'h40400000);
    check("bp_new_op", 64'(fpu_add_subt), 64'd1);
    check("bp_new_rmode", 64'(fpu_r_mode), 64'd1);
    wait_out(n);
    check("sub_latency", 64'(n), 64'd2);
    check("sub_result", 64'(out_result), 64'h40000000);
    check("sub_cycles", 64'(out_cycles), 64'd1);
    tick();
    check("sub_popped", 64'(out_valid), 64'd0);

    // Timeout: stub never answers
    stub_delay = 8'd0; fixed_res = 32'hDEADBEEF; fixed_ovf = 1'b1; fixed_unf = 1'b1;
    issue("to", 32'h11111111, 32'h22222222, 1'b0, 2'd0);
    wait_out(n);
    check("to_latency", 64'(n), 64'd65);
    check("to_flag", 64'(out_timeout), 64'd1);
    check("to_result", 64'(out_result), 64'd0);
    check("to_ovf", 64'(out_ovf), 64'd0);
    check("to_unf", 64'(out_unf), 64'd0);
    check("to_cycles", 64'(out_cycles), 64'd64);
    check("to_rstfsm", 64'(fpu_rst_FSM), 64'd1);
    tick();
    check("to_popped", 64'(out_valid), 64'd0);

    // Next op after timeout completes normally
    stub_delay = 8'd3; fixed_res = 32'h12345678; fixed_ovf = 1'b1; fixed_unf = 1'b0;
    issue("post", 32'h33333333, 32'h44444444, 1'b1, 2'd3);
    wait_out(n);
    check("post_latency", 64'(n), 64'd4);
    check("post_result", 64'(out_result), 64'h12345678);
    check("post_ovf", 64'(out_ovf), 64'd1);
    check("post_unf", 64'(out_unf), 64'd0);
    check("post_timeout", 64'(out_timeout), 64'd0);
    check("post_cycles", 64'(out_cycles), 64'd3);
    tick();

    // Race: ready in the same cycle the watchdog reaches TIMEOUT-1
    stub_delay = 8'd64; fixed_res = 32'h0BADF00D; fixed_ovf = 1'b0; fixed_unf = 1'b1;
    issue("race", 32'h55555555, 32'h66666666, 1'b0, 2'd1);
    wait_out(n);
    check("race_latency", 64'(n), 64'd65);
    check("race_timeout", 64'(out_timeout), 64'd0);
    check("race_result", 64'(out_result), 64'h0BADF00D);
    check("race_unf", 64'(out_unf), 64'd1);
    check("race_cycles", 64'(out_cycles), 64'd64);
    tick();

    // Reset in the middle of WAIT
    stub_delay = 8'd20;
    issue("mid", 32'h77777777, 32'h88888888, 1'b1, 2'd2);
    repeat (5) tick();
    check("mid_busy_before", 64'(busy), 64'd1);
    saved = rstfsm_cnt;
    rst = 1'b0;
    tick();
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_in_ready", 64'(in_ready), 64'd1);
    check("mid_rst_data_x", 64'(fpu_Data_X), 64'd0);
    check("mid_rst_add_subt", 64'(fpu_add_subt), 64'd0);
    check("mid_rst_result", 64'(out_result), 64'd0);
    check("mid_rst_unf", 64'(out_unf), 64'd0);
    check("mid_rst_cycles", 64'(out_cycles), 64'd0);
    check("mid_rst_valid", 64'(out_valid), 64'd0);
    check("mid_rst_rstfsm", 64'(fpu_rst_FSM), 64'd0);
    rst = 1'b1;
    repeat (3) tick();
    check("mid_no_rstfsm", 64'(rstfsm_cnt), 64'(saved));
    check("mid_idle", 64'(busy), 64'd0);

    // Random stream with random downstream back-pressure
    stub_random = 1'b1;
    issued = 0; rx = 0; guard = 0;
    while (rx < 20 && guard < 5000) begin
      out_ready = 1'($urandom_range(0, 1));
      if (!in_valid && issued < 20 && $urandom_range(0, 3) != 0) begin
        in_x = $urandom; in_y = $urandom;
        in_add_subt = 1'($urandom_range(0, 1)); in_r_mode = 2'($urandom_range(0, 3));
        in_valid = 1'b1;
      end
      #1;
      acc = in_valid && in_ready;
      if (acc) begin
        e.res = mix(in_x, in_y, in_add_subt);
        e.ovf = in_x[4] ^ in_y[0];
        e.unf = in_y[5];
        e.cyc = 7'(in_x[3:0] % 4'd10) + 7'd1;
        exp_q.push_back(e);
        issued++;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("stream_unexpected", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("stream_result", 64'(out_result), 64'(e.res));
          check("stream_ovf", 64'(out_ovf), 64'(e.ovf));
          check("stream_unf", 64'(out_unf), 64'(e.unf));
          check("stream_cycles", 64'(out_cycles), 64'(e.cyc));
          check("stream_timeout", 64'(out_timeout), 64'd0);
        end
        rx++;
      end
      tick();
      guard++;
      if (acc) in_valid = 1'b0;
    end
    out_ready = 1'b1;
    repeat (2) tick();
    check("stream_count", 64'(rx), 64'd20);
    check("total_beg", 64'(beg_cnt), 64'd26);
    check("total_rstfsm", 64'(rstfsm_cnt), 64'd25);
    check("handshake_violations", 64'(viol), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
